mult_array: RTL and testbench

//  Array of NUM_PES multiplier switches directly downstream of the distribution crossbar.
//  - Consumes the crossbar's registered per-PE operand bus.
//  - A load beat latches one stationary operand per selected PE.
//  - Each later stream beat multiplies the incoming operand by that PE's stationary value.
//  - Products and a per-PE valid mask go to the reduction network.

---
 rtl/mult_array_pkg.sv | 21 ++
 rtl/mult_array_pe.sv | 93 +++++++++
 rtl/mult_array.sv | 110 +++++++++++
 tb/tb_mult_array.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_array_pkg.sv
// mult_array_pkg
// Shared types and sizing for the multiplier-switch array.
//   state_e  : array FSM state (IDLE / LOADED / STREAM)
//   PROD_W   : product width for the default operand width
//   prod_w() : full-precision signed product width for a given operand width
package mult_array_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam int DATA_TYPE_DEF = 16;
  localparam int PROD_W        = 2 * DATA_TYPE_DEF;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/mult_array_pe.sv
// mult_pe
// One multiplier switch. It holds a stationary operand plus its valid bit,
// and multiplies each stream operand by it in a two-stage pipeline.
// Optional feature macro: MULT_ZERO_GATE_EN. When it is defined, a beat
// where either operand is zero does not load the operand registers, and the
// PE reports no product for that beat.
// Ports:
//   clk, rst  : clock, async active-low reset
//   i_flush   : drop the stationary-valid bit
//   i_load    : latch i_op as the stationary operand (already gated by mask)
//   i_strm    : stream beat accepted this cycle
//   i_mask    : this PE participates in the stream beat
//   i_s1_vld  : stage-1 of the array holds a beat
//   i_op      : operand from the distribution bus
//   o_stat_v  : stationary operand loaded
//   o_mask    : stage-2 product is meaningful
//   o_prod    : stage-2 signed product, 0 when o_mask is low
module mult_pe
  import mult_array_pkg::*;
#(
  parameter int DATA_TYPE = DATA_TYPE_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_flush,
  input  logic                              i_load,
  input  logic                              i_strm,
  input  logic                              i_mask,
  input  logic                              i_s1_vld,
  input  logic signed [DATA_TYPE-1:0]       i_op,
  output logic                              o_stat_v,
  output logic                              o_mask,
  output logic signed [2*DATA_TYPE-1:0]     o_prod
);
  localparam int PW = prod_w(DATA_TYPE);

  logic signed [DATA_TYPE-1:0] r_stat, r_a, r_b;
  logic                        r_stat_v, r_m1, r_m2;
  logic signed [PW-1:0]        r_prod;
  logic                        w_take;
  logic signed [PW-1:0]        w_prod;

`ifdef MULT_ZERO_GATE_EN
  assign w_take = i_mask & r_stat_v & (i_op != '0) & (r_stat != '0);
`else
  assign w_take = i_mask & r_stat_v;
`endif

  assign w_prod = PW'(r_a) * PW'(r_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat   <= '0;
      r_stat_v <= 1'b0;
    end else if (i_flush) begin
      r_stat_v <= 1'b0;
    end else if (i_load) begin
      r_stat   <= i_op;
      r_stat_v <= 1'b1;
    end
  end

  // Stage 1 copies the stationary value next to the stream operand. A load
  // that follows right behind therefore cannot change a product in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_m1 <= 1'b0;
    end else if (i_strm) begin
      r_m1 <= w_take;
      if (w_take) begin
        r_a <= r_stat;
        r_b <= i_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod <= '0;
      r_m2   <= 1'b0;
    end else begin
      r_m2   <= i_s1_vld & r_m1;
      r_prod <= (i_s1_vld & r_m1) ? w_prod : '0;
    end
  end

  assign o_stat_v = r_stat_v;
  assign o_mask   = r_m2;
  assign o_prod   = r_prod;

endmodule

// File: rtl/mult_array.sv
// mult_array
// An array of NUM_PES weight-stationary multiplier switches that sits after
// the distribution crossbar. Load beats latch stationary operands. Stream
// beats produce full-width signed products two cycles later.
// Optional feature macro: MULT_ZERO_GATE_EN (sparsity skip, see mult_pe).
// Ports:
//   clk, rst     : clock, async active-low reset
//   i_valid      : beat present on i_dist_bus
//   i_stat_load  : 1 = load beat, 0 = stream beat
//   i_pe_mask    : PEs taking part in the beat
//   i_flush      : clear stationary-valid bits, counter, error; go IDLE
//   i_dist_bus   : per-PE operands, PE i at [i*DATA_TYPE +: DATA_TYPE]
//   o_valid      : product outputs valid
//   o_prod_mask  : PEs whose product is meaningful
//   o_prod_bus   : per-PE products, PE i at [i*2*DATA_TYPE +: 2*DATA_TYPE]
//   o_beat_cnt   : stream beats since the last load or flush
//   o_err        : sticky error, a stream beat hit an unloaded PE
module mult_array
  import mult_array_pkg::*;
#(
  parameter int DATA_TYPE = DATA_TYPE_DEF,
  parameter int NUM_PES   = 32,
  parameter int CNT_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  input  logic                               i_stat_load,
  input  logic [NUM_PES-1:0]                 i_pe_mask,
  input  logic                               i_flush,
  input  logic [NUM_PES*DATA_TYPE-1:0]       i_dist_bus,
  output logic                               o_valid,
  output logic [NUM_PES-1:0]                 o_prod_mask,
  output logic [NUM_PES*2*DATA_TYPE-1:0]     o_prod_bus,
  output logic [CNT_W-1:0]                   o_beat_cnt,
  output logic                               o_err
);
  localparam int PW = prod_w(DATA_TYPE);

  state_e                              r_state, w_state_nxt;
  logic [2:1]                          r_vld_pipe;
  logic [CNT_W-1:0]                    r_cnt;
  logic                                r_err;
  logic                                w_load, w_strm;
  logic [NUM_PES-1:0]                  w_stat_v, w_pmask;
  logic [NUM_PES-1:0][PW-1:0]          w_prod;
  logic [NUM_PES-1:0][DATA_TYPE-1:0]   w_op;

  assign w_op = i_dist_bus;

  // A flush wins over a beat in the same cycle, and the beat is dropped.
  assign w_load = i_valid &  i_stat_load & ~i_flush;
  assign w_strm = i_valid & ~i_stat_load & ~i_flush;

  genvar g;
  generate
    for (g = 0; g < NUM_PES; g++) begin : g_pe
      mult_pe #(.DATA_TYPE(DATA_TYPE)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (i_flush),
        .i_load   (w_load & i_pe_mask[g]),
        .i_strm   (w_strm),
        .i_mask   (i_pe_mask[g]),
        .i_s1_vld (r_vld_pipe[1]),
        .i_op     (w_op[g]),
        .o_stat_v (w_stat_v[g]),
        .o_mask   (w_pmask[g]),
        .o_prod   (w_prod[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush)                         w_state_nxt = IDLE;
    else if (w_load)                     w_state_nxt = LOADED;
    else if (w_strm && r_state == LOADED) w_state_nxt = STREAM;
  end

  // Stage-1 valid only takes accepted stream beats, so a flush clears it.
  // A beat already in stage 1 still moves on to stage 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], w_strm};
      if (i_flush || w_load) r_cnt <= '0;
      else if (w_strm)       r_cnt <= r_cnt + CNT_W'(1);
      if (i_flush)
        r_err <= 1'b0;
      else if (w_strm && (r_state == IDLE || |(i_pe_mask & ~w_stat_v)))
        r_err <= 1'b1;
    end
  end

  assign o_valid     = r_vld_pipe[2];
  assign o_prod_mask = w_pmask;
  assign o_prod_bus  = w_prod;
  assign o_beat_cnt  = r_cnt;
  assign o_err       = r_err;

endmodule

// File: tb/tb_mult_array.sv
module tb_mult_array;
  localparam int NP = 32;
  localparam int DW = 16;
  localparam int PW = 32;
  localparam int CW = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid, i_stat_load, i_flush;
  logic [NP-1:0]      i_pe_mask;
  logic [NP*DW-1:0]   i_dist_bus;
  logic               o_valid;
  logic [NP-1:0]      o_prod_mask;
  logic [NP*PW-1:0]   o_prod_bus;
  logic [CW-1:0]      o_beat_cnt;
  logic               o_err;

  int n_chk = 0;
  int n_fail = 0;

  mult_array #(.DATA_TYPE(DW), .NUM_PES(NP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_stat_load(i_stat_load),
    .i_pe_mask(i_pe_mask), .i_flush(i_flush), .i_dist_bus(i_dist_bus),
    .o_valid(o_valid), .o_prod_mask(o_prod_mask), .o_prod_bus(o_prod_bus),
    .o_beat_cnt(o_beat_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Reference model: stationary table, loaded flag, counter, error, and the
  // products of the beat in flight plus the one on the outputs.
  logic [DW-1:0] m_stat [NP];
  logic [NP-1:0] m_sv;
  logic          m_loaded, m_err;
  logic [CW-1:0] m_cnt;
  logic          pv, ov;
  logic [NP-1:0] pm, om;
  logic [PW-1:0] pp [NP];
  logic [PW-1:0] eo [NP];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin m_stat[i] = '0; pp[i] = '0; eo[i] = '0; end
    m_sv = '0; m_loaded = 0; m_err = 0; m_cnt = '0;
    pv = 0; ov = 0; pm = '0; om = '0;
  endtask

  task automatic model_edge(input logic v, ld, fl, input logic [NP-1:0] m,
                            input logic [NP*DW-1:0] bus);
    logic signed [DW-1:0] sa, sb;
    int a, b;
    logic take;
    ov = pv; om = pm;
    for (int i = 0; i < NP; i++) begin eo[i] = pp[i]; pp[i] = '0; end
    pv = 0; pm = '0;
    if (fl) begin
      m_sv = '0; m_cnt = '0; m_err = 0; m_loaded = 0;
    end else if (v && ld) begin
      for (int i = 0; i < NP; i++)
        if (m[i]) begin m_stat[i] = bus[i*DW +: DW]; m_sv[i] = 1'b1; end
      m_cnt = '0; m_loaded = 1;
    end else if (v) begin
      pv = 1;
      for (int i = 0; i < NP; i++) begin
        sa = m_stat[i]; sb = bus[i*DW +: DW];
        a = sa; b = sb;
        take = m[i] & m_sv[i];
`ifdef MULT_ZERO_GATE_EN
        if (a == 0 || b == 0) take = 0;
`endif
        if (take) begin pm[i] = 1'b1; pp[i] = a * b; end
      end
      if (!m_loaded || (m & ~m_sv) != '0) m_err = 1;
      m_cnt = m_cnt + 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'(ov));
    chk({tag, "_mask"}, 64'(o_prod_mask), 64'(om));
    chk({tag, "_cnt"}, 64'(o_beat_cnt), 64'(m_cnt));
    chk({tag, "_err"}, 64'(o_err), 64'(m_err));
    for (int i = 0; i < NP; i++)
      chk($sformatf("%s_prod%0d", tag, i), 64'(o_prod_bus[i*PW +: PW]), 64'(eo[i]));
  endtask

  task automatic step(input string tag, input logic v, ld, fl,
                      input logic [NP-1:0] m, input logic [NP*DW-1:0] bus);
    i_valid = v; i_stat_load = ld; i_flush = fl; i_pe_mask = m; i_dist_bus = bus;
    @(posedge clk); #1;
    model_edge(v, ld, fl, m, bus);
    check_all(tag);
  endtask

  function automatic logic [NP*DW-1:0] all_op(input logic [DW-1:0] x);
    logic [NP*DW-1:0] b;
    for (int i = 0; i < NP; i++) b[i*DW +: DW] = x;
    return b;
  endfunction

  function automatic logic [NP*DW-1:0] ramp(input int base);
    logic [NP*DW-1:0] b;
    for (int i = 0; i < NP; i++) b[i*DW +: DW] = DW'(base + i);
    return b;
  endfunction

  localparam logic [NP-1:0] ALL = '1;

  initial begin
    logic [NP*DW-1:0] bus;
    logic [NP-1:0] m;
    logic v, ld, fl;
    int k;
    rst = 1'b0; i_valid = 0; i_stat_load = 0; i_flush = 0; i_pe_mask = '0; i_dist_bus = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Load ops i+1, stream 2: the product appears two edges after the beat is driven
    step("t1_load", 1, 1, 0, ALL, ramp(1));
    step("t1_strm", 1, 0, 0, ALL, all_op(16'd2));
    step("t1_out", 0, 0, 0, '0, '0);
    chk("t1_valid", 64'(o_valid), 64'd1);
    chk("t1_cnt", 64'(o_beat_cnt), 64'd1);
    chk("t1_mask", 64'(o_prod_mask), 64'hFFFF_FFFF);
    for (int i = 0; i < NP; i++)
      chk($sformatf("t1_p%0d", i), 64'(o_prod_bus[i*PW +: PW]), 64'(2 * (i + 1)));

    // PE0 alone loaded with -3, stream hits PE0 and PE1
    step("t2_flush", 0, 0, 1, '0, '0);
    bus = '0; bus[DW-1:0] = 16'hFFFD;
    step("t2_load", 1, 1, 0, 32'h1, bus);
    step("t2_strm", 1, 0, 0, 32'h3, all_op(16'd5));
    step("t2_out", 0, 0, 0, '0, '0);
    chk("t2_p0", 64'(o_prod_bus[PW-1:0]), 64'h0000_0000_FFFF_FFF1);
    chk("t2_mask", 64'(o_prod_mask), 64'h1);
    chk("t2_err", 64'(o_err), 64'h1);

    // Four back-to-back stream beats come out in order
    step("t3_flush", 0, 0, 1, '0, '0);
    step("t3_load", 1, 1, 0, ALL, ramp(1));
    for (k = 0; k < 6; k++) begin
      if (k < 4) step("t3_strm", 1, 0, 0, ALL, all_op(DW'(10 + k)));
      else       step("t3_idle", 0, 0, 0, '0, '0);
      if (k == 3) chk("t3_cnt4", 64'(o_beat_cnt), 64'd4);
      if (k >= 1 && k <= 4) begin
        chk("t3_valid", 64'(o_valid), 64'd1);
        chk("t3_p1", 64'(o_prod_bus[PW +: PW]), 64'(2 * (10 + k - 1)));
      end
    end

    // Flush in the same cycle as a stream beat drops that beat
    step("t4_strmA", 1, 0, 0, ALL, all_op(16'd3));
    step("t4_flushB", 1, 0, 1, ALL, all_op(16'd4));
    step("t4_idle1", 0, 0, 0, '0, '0);
    chk("t4_valid", 64'(o_valid), 64'd0);
    chk("t4_cnt", 64'(o_beat_cnt), 64'd0);
    chk("t4_err", 64'(o_err), 64'd0);

    // Zero stream operand on PE3
    step("t5_load", 1, 1, 0, ALL, all_op(16'd7));
    bus = all_op(16'd1); bus[3*DW +: DW] = '0;
    step("t5_strm", 1, 0, 0, ALL, bus);
    step("t5_out", 0, 0, 0, '0, '0);
    chk("t5_p3", 64'(o_prod_bus[3*PW +: PW]), 64'd0);
`ifdef MULT_ZERO_GATE_EN
    chk("t5_m3", 64'(o_prod_mask[3]), 64'd0);
`else
    chk("t5_m3", 64'(o_prod_mask[3]), 64'd1);
`endif

    // Most negative times most negative
    step("t6_load", 1, 1, 0, ALL, all_op(16'h8000));
    step("t6_strm", 1, 0, 0, ALL, all_op(16'h8000));
    step("t6_out", 0, 0, 0, '0, '0);
    chk("t6_p0", 64'(o_prod_bus[PW-1:0]), 64'h4000_0000);
    chk("t6_p31", 64'(o_prod_bus[31*PW +: PW]), 64'h4000_0000);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      fl = ($urandom_range(0, 99) < 4);
      v  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 5) == 0);
      m  = $urandom;
      if ($urandom_range(0, 7) == 0) m = ALL;
      for (int i = 0; i < NP; i++) begin
        case ($urandom_range(0, 7))
          0: bus[i*DW +: DW] = '0;
          1: bus[i*DW +: DW] = 16'h8000;
          2: bus[i*DW +: DW] = 16'h7FFF;
          default: bus[i*DW +: DW] = DW'($urandom);
        endcase
      end
      step("rnd", v, ld, fl, m, bus);
    end

    // Asynchronous reset while beats are in flight
    step("t7_load", 1, 1, 0, ALL, ramp(3));
    step("t7_s1", 1, 0, 0, ALL, all_op(16'd9));
    step("t7_s2", 1, 0, 0, ALL, all_op(16'd11));
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t7_async");
    i_valid = 0; i_stat_load = 0; i_flush = 0; i_pe_mask = '0; i_dist_bus = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) step("t7_post", 0, 0, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
